// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: counters, registered sync/blank aligned with hpos/vpos,
// pix_en-qualified strobes, frame counter. Define VGA_TIMING_PREFETCH_EN for the look-ahead port.
`timescale 1ns/1ps

module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned HW       = 10,
  parameter int unsigned VW       = 10,
  parameter int unsigned PF_LEAD  = 2
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          pix_en,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic          hsync,
  output logic          vsync,
  output logic          hactive,
  output logic          vactive,
  output logic          active,
  output logic          line_pulse,
  output logic          frame_pulse,
  output logic [7:0]    frame_cnt,
  output logic          fetch_act,
  output logic [HW-1:0] fetch_x,
  output logic [VW-1:0] fetch_y
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Bad geometry must stop elaboration rather than produce a silently wrapping raster.
  if (H_ACTIVE == 0 || H_SYNC == 0 || V_ACTIVE == 0 || V_SYNC == 0) begin : g_bad_zero
    $error("vga_timing_gen: active and sync widths must be non-zero");
  end
  if (HW == 0 || ((H_TOTAL - 1) >> HW) != 0) begin : g_bad_hw
    $error("vga_timing_gen: HW too narrow for H_TOTAL-1");
  end
  if (VW == 0 || ((V_TOTAL - 1) >> VW) != 0) begin : g_bad_vw
    $error("vga_timing_gen: VW too narrow for V_TOTAL-1");
  end

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] hpos_q, hpos_d;
  logic [VW-1:0] vpos_q, vpos_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          hactive_q, hactive_d;
  logic          vactive_q, vactive_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          h_wrap, v_wrap;

  assign h_wrap = (hpos_q == H_LAST);
  assign v_wrap = (vpos_q == V_LAST);

  always_comb begin
    hpos_d      = hpos_q;
    vpos_d      = vpos_q;
    frame_cnt_d = frame_cnt_q;
    if (pix_en) begin
      if (h_wrap) begin
        hpos_d = '0;
        if (v_wrap) begin
          vpos_d      = '0;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
          vpos_d = vpos_q + VW'(1);
        end
      end else begin
        hpos_d = hpos_q + HW'(1);
      end
    end
  end

  // Decoding the next counter values keeps sync/blank in the same cycle as hpos/vpos.
  always_comb begin
    hsync_d   = ((hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST)) ? H_POL : ~H_POL;
    vsync_d   = ((vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST)) ? V_POL : ~V_POL;
    hactive_d = (hpos_d <= H_ACT_LAST);
    vactive_d = (vpos_d <= V_ACT_LAST);
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      hpos_q      <= '0;
      vpos_q      <= '0;
      hsync_q     <= ~H_POL;
      vsync_q     <= ~V_POL;
      hactive_q   <= 1'b1;
      vactive_q   <= 1'b1;
      frame_cnt_q <= 8'd0;
    end else begin
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      hactive_q   <= hactive_d;
      vactive_q   <= vactive_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hactive     = hactive_q;
  assign vactive     = vactive_q;
  assign active      = hactive_q & vactive_q;
  assign line_pulse  = pix_en & h_wrap;
  assign frame_pulse = pix_en & h_wrap & v_wrap;
  assign frame_cnt   = frame_cnt_q;

`ifdef VGA_TIMING_PREFETCH_EN
  if (PF_LEAD == 0 || PF_LEAD > H_FP + H_SYNC + H_BP) begin : g_bad_pf
    $error("vga_timing_gen: PF_LEAD out of range");
  end

  localparam logic [HW-1:0] FX_RST  = HW'(PF_LEAD);
  localparam logic          FA_RST  = (PF_LEAD < H_ACTIVE);

  logic [HW-1:0] fx_q, fx_d;
  logic [VW-1:0] fy_q, fy_d;
  logic          fa_q, fa_d;

  // Second raster counter held PF_LEAD ticks ahead; it wraps on its own line/frame boundary.
  always_comb begin
    fx_d = fx_q;
    fy_d = fy_q;
    if (pix_en) begin
      if (fx_q == H_LAST) begin
        fx_d = '0;
        fy_d = (fy_q == V_LAST) ? '0 : fy_q + VW'(1);
      end else begin
        fx_d = fx_q + HW'(1);
      end
    end
    fa_d = (fx_d <= H_ACT_LAST) && (fy_d <= V_ACT_LAST);
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      fx_q <= FX_RST;
      fy_q <= '0;
      fa_q <= FA_RST;
    end else begin
      fx_q <= fx_d;
      fy_q <= fy_d;
      fa_q <= fa_d;
    end
  end

  assign fetch_act = fa_q;
  assign fetch_x   = fx_q;
  assign fetch_y   = fy_q;
`else
  assign fetch_act = 1'b0;
  assign fetch_x   = '0;
  assign fetch_y   = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a tiny 14x7 mode for whole-frame/wrap cases and the default
// 800x525 mode for line-level checks.
`timescale 1ns/1ps

module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Small mode: H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), active-high syncs.
  logic       s_rst_n, s_pe;
  logic [3:0] s_hpos, s_fx;
  logic [2:0] s_vpos, s_fy;
  logic       s_hs, s_vs, s_ha, s_va, s_act, s_line, s_frame, s_fa;
  logic [7:0] s_fc;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .HW(4), .VW(3), .PF_LEAD(2)
  ) u_small (
    .clk(clk), .nRst(s_rst_n), .pix_en(s_pe),
    .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hs), .vsync(s_vs),
    .hactive(s_ha), .vactive(s_va), .active(s_act),
    .line_pulse(s_line), .frame_pulse(s_frame), .frame_cnt(s_fc),
    .fetch_act(s_fa), .fetch_x(s_fx), .fetch_y(s_fy)
  );

  logic       d_rst_n, d_pe;
  logic [9:0] d_hpos, d_vpos, d_fx, d_fy;
  logic       d_hs, d_vs, d_ha, d_va, d_act, d_line, d_frame, d_fa;
  logic [7:0] d_fc;

  vga_timing_gen u_dflt (
    .clk(clk), .nRst(d_rst_n), .pix_en(d_pe),
    .hpos(d_hpos), .vpos(d_vpos), .hsync(d_hs), .vsync(d_vs),
    .hactive(d_ha), .vactive(d_va), .active(d_act),
    .line_pulse(d_line), .frame_pulse(d_frame), .frame_cnt(d_fc),
    .fetch_act(d_fa), .fetch_x(d_fx), .fetch_y(d_fy)
  );

  typedef struct {
    bit rst_n; bit pe; int n;
    bit e_line; bit e_frame;
    int e_h; int e_v; bit e_hs; bit e_vs; bit e_ha; bit e_va; int e_fc;
  } vec_t;

  vec_t tbl[18];

  // Model of the small DUT for the sweep sections.
  int mh, mv, mfc;

  task automatic chk_small_fetch();
    int fx, fy;
    fx = mh + 2;
    fy = mv;
    if (fx >= 14) begin
      fx -= 14;
      fy = (fy == 6) ? 0 : fy + 1;
    end
`ifdef VGA_TIMING_PREFETCH_EN
    chk("s_fetch_x", s_fx, fx);
    chk("s_fetch_y", s_fy, fy);
    chk("s_fetch_act", s_fa, (fx < 8 && fy < 4));
`else
    chk("s_fetch_x", s_fx, 0);
    chk("s_fetch_y", s_fy, 0);
    chk("s_fetch_act", s_fa, 0);
`endif
  endtask

  task automatic chk_small();
    chk("s_hpos", s_hpos, mh);
    chk("s_vpos", s_vpos, mv);
    chk("s_hsync", s_hs, (mh >= 10 && mh <= 11));
    chk("s_vsync", s_vs, (mv == 5));
    chk("s_hactive", s_ha, (mh < 8));
    chk("s_vactive", s_va, (mv < 4));
    chk("s_active", s_act, (mh < 8 && mv < 4));
    chk("s_frame_cnt", s_fc, mfc);
    chk_small_fetch();
  endtask

  task automatic s_tick(input bit pe, input bit chk_strb);
    s_pe = pe;
    #1;
    if (chk_strb) begin
      chk("s_line_pulse", s_line, (pe && mh == 13));
      chk("s_frame_pulse", s_frame, (pe && mh == 13 && mv == 6));
    end
    @(posedge clk);
    if (pe) begin
      if (mh == 13) begin
        mh = 0;
        if (mv == 6) begin
          mv = 0;
          mfc = (mfc + 1) % 256;
        end else begin
          mv++;
        end
      end else begin
        mh++;
      end
    end
    #1;
  endtask

  initial begin
    int dh, dv, npulse, t0, t1, guard, strb_seen;

    //                rst pe  n  line frm  h  v hs vs ha va fc
    tbl[0]  = '{1, 1,  1, 0, 0,  1, 0, 0, 0, 1, 1, 0};
    tbl[1]  = '{1, 0,  5, 0, 0,  1, 0, 0, 0, 1, 1, 0};
    tbl[2]  = '{1, 1,  7, 0, 0,  8, 0, 0, 0, 0, 1, 0};
    tbl[3]  = '{1, 1,  2, 0, 0, 10, 0, 1, 0, 0, 1, 0};
    tbl[4]  = '{1, 1,  1, 0, 0, 11, 0, 1, 0, 0, 1, 0};
    tbl[5]  = '{1, 1,  1, 0, 0, 12, 0, 0, 0, 0, 1, 0};
    tbl[6]  = '{1, 1,  1, 0, 0, 13, 0, 0, 0, 0, 1, 0};
    tbl[7]  = '{1, 0,  3, 0, 0, 13, 0, 0, 0, 0, 1, 0};
    tbl[8]  = '{1, 1,  1, 1, 0,  0, 1, 0, 0, 1, 1, 0};
    tbl[9]  = '{1, 1, 42, 1, 0,  0, 4, 0, 0, 1, 0, 0};
    tbl[10] = '{1, 1, 14, 1, 0,  0, 5, 0, 1, 1, 0, 0};
    tbl[11] = '{1, 1, 13, 0, 0, 13, 5, 0, 1, 0, 0, 0};
    tbl[12] = '{1, 1,  1, 1, 0,  0, 6, 0, 0, 1, 0, 0};
    tbl[13] = '{1, 1, 13, 0, 0, 13, 6, 0, 0, 0, 0, 0};
    tbl[14] = '{1, 1,  1, 1, 1,  0, 0, 0, 0, 1, 1, 1};
    tbl[15] = '{1, 1, 20, 0, 0,  6, 1, 0, 0, 1, 1, 1};
    tbl[16] = '{0, 1,  1, 0, 0,  0, 0, 0, 0, 1, 1, 0};
    tbl[17] = '{1, 1, 98, 1, 1,  0, 0, 0, 0, 1, 1, 1};

    s_rst_n = 1'b0; s_pe = 1'b1;
    d_rst_n = 1'b0; d_pe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mh = 0; mv = 0; mfc = 0;
    chk_small();

    foreach (tbl[i]) begin
      s_rst_n = tbl[i].rst_n;
      s_pe    = tbl[i].pe;
      repeat (tbl[i].n - 1) @(posedge clk);
      #1;
      chk($sformatf("v%0d_line", i), s_line, tbl[i].e_line);
      chk($sformatf("v%0d_frame", i), s_frame, tbl[i].e_frame);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_hpos", i), s_hpos, tbl[i].e_h);
      chk($sformatf("v%0d_vpos", i), s_vpos, tbl[i].e_v);
      chk($sformatf("v%0d_hsync", i), s_hs, tbl[i].e_hs);
      chk($sformatf("v%0d_vsync", i), s_vs, tbl[i].e_vs);
      chk($sformatf("v%0d_hactive", i), s_ha, tbl[i].e_ha);
      chk($sformatf("v%0d_vactive", i), s_va, tbl[i].e_va);
      chk($sformatf("v%0d_frame_cnt", i), s_fc, tbl[i].e_fc);
    end

    // Half-rate sweep over two full frames, every output each cycle.
    mh = 0; mv = 0; mfc = 1;
    for (int c = 0; c < 392; c++) begin
      s_tick(c % 2 == 0, 1'b1);
      chk_small();
    end

    // Freeze: pix_en low for 50 clocks must hold everything and suppress strobes.
    repeat (23) s_tick(1'b1, 1'b0);
    chk_small();
    strb_seen = 0;
    for (int c = 0; c < 50; c++) begin
      s_tick(1'b0, 1'b0);
      if (s_line !== 1'b0 || s_frame !== 1'b0) strb_seen++;
    end
    chk("s_freeze_strobes", strb_seen, 0);
    chk_small();

    // Run up to frame_cnt 255, then across one more frame end.
    guard = 0;
    while (!(mfc == 255 && mh == 0 && mv == 0) && guard < 30000) begin
      s_tick(1'b1, 1'b0);
      guard++;
    end
    chk("s_reach_fc255", guard < 30000, 1);
    chk_small();
    repeat (97) s_tick(1'b1, 1'b0);
    s_tick(1'b1, 1'b1);
    chk_small();
    chk("s_fc_wrapped", s_fc, 0);

    // Default 640x480 mode.
    d_pe = 1'b1;
    @(posedge clk);
    #1;
    chk("d_rst_hpos", d_hpos, 0);
    chk("d_rst_vpos", d_vpos, 0);
    chk("d_rst_hsync", d_hs, 1);
    chk("d_rst_vsync", d_vs, 1);
    chk("d_rst_active", d_act, 1);
    chk("d_rst_fc", d_fc, 0);
`ifndef VGA_TIMING_PREFETCH_EN
    chk("d_rst_fetch", {d_fa, d_fx, d_fy}, 0);
`endif

    d_rst_n = 1'b1;
    dh = 0; dv = 0;
    for (int c = 0; c < 800; c++) begin
      d_pe = 1'b1;
      #1;
      chk("d_line_pulse", d_line, (dh == 799));
      chk("d_frame_pulse", d_frame, 0);
      @(posedge clk);
      if (dh == 799) begin
        dh = 0;
        dv++;
      end else begin
        dh++;
      end
      #1;
      chk("d_hpos", d_hpos, dh);
      chk("d_vpos", d_vpos, dv);
      chk("d_hsync", d_hs, !(dh >= 656 && dh <= 751));
      chk("d_vsync", d_vs, 1);
      chk("d_hactive", d_ha, (dh < 640));
      chk("d_active", d_act, (dh < 640));
`ifdef VGA_TIMING_PREFETCH_EN
      chk("d_fetch_x", d_fx, (dh + 2) % 800);
`else
      chk("d_fetch_x", d_fx, 0);
`endif
    end

    // Half-rate pix_en stretches the line to 1600 clocks.
    npulse = 0; t0 = 0; t1 = 0;
    for (int c = 0; c < 4000 && npulse < 2; c++) begin
      d_pe = (c % 2 == 0);
      #1;
      if (d_line === 1'b1) begin
        if (npulse == 0) t0 = c;
        else t1 = c;
        npulse++;
      end
      @(posedge clk);
      #1;
    end
    chk("d_half_rate_pulses", npulse, 2);
    chk("d_half_rate_period", t1 - t0, 1600);

    // Reset mid-line must return to origin on the next edge.
    d_pe = 1'b1;
    repeat (300) @(posedge clk);
    d_rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("d_midreset_hpos", d_hpos, 0);
    chk("d_midreset_vpos", d_vpos, 0);
    chk("d_midreset_hsync", d_hs, 1);
    chk("d_midreset_fc", d_fc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
